// File: rtl/fb_scanout_if.sv
// CPU-side framebuffer write port: one cell write per clock while fb_we is high.
interface fb_scanout_if;
    logic [12:0] fb_addr;
    logic [7:0]  fb_data;
    logic        fb_we;

    modport master (output fb_addr, output fb_data, output fb_we);
    modport slave  (input  fb_addr, input  fb_data, input  fb_we);
endinterface

// File: rtl/fb_scanout.sv
// 80x60 RGB332 cell framebuffer scanned out as 640x480@60 VGA with a 2-cycle
// pipeline (buffer read, then output registers) keeping syncs and colour aligned.
module fb_scanout #(
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FP     = 16,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BP     = 48,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FP     = 10,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BP     = 33,
    parameter int unsigned CELLS_X  = H_ACTIVE / 8,
    parameter int unsigned FB_DEPTH = 4800
) (
    input  logic         clk,
    input  logic         rst_n,
    fb_scanout_if.slave  fb,
    output logic [3:0]   vga_r,
    output logic [3:0]   vga_g,
    output logic [3:0]   vga_b,
    output logic         vga_hs,
    output logic         vga_vs,
    output logic         vblank,
    output logic         frame_start
);

    localparam int unsigned CNT_W    = 10;
    localparam int unsigned ADDR_W   = 13;
    localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned HS_START = H_ACTIVE + H_FP;
    localparam int unsigned HS_STOP  = HS_START + H_SYNC;
    localparam int unsigned VS_START = V_ACTIVE + V_FP;
    localparam int unsigned VS_STOP  = VS_START + V_SYNC;

    logic [7:0] mem [FB_DEPTH];

    logic [CNT_W-1:0]  h_cnt_q, h_cnt_d, v_cnt_q, v_cnt_d;
    logic [ADDR_W-1:0] row_base_q, row_base_d;

    // stage 1: buffer read data plus flags decoded from the counters
    logic [7:0] rd_data_q;
    logic       act1_q, act1_d, hs1_q, hs1_d, vs1_q, vs1_d, vb1_q, vb1_d, fs1_q, fs1_d;

    // stage 2: output registers
    logic [3:0] r_q, r_d, g_q, g_d, b_q, b_d;
    logic       hs_q, hs_d, vs_q, vs_d, vb_q, vb_d, fs_q, fs_d;

    logic              h_wrap_c, v_wrap_c, active_c, wr_ok_c;
    logic [ADDR_W-1:0] rd_addr_c;

    always_comb begin
        h_wrap_c   = (h_cnt_q == CNT_W'(H_TOTAL - 1));
        v_wrap_c   = (v_cnt_q == CNT_W'(V_TOTAL - 1));
        active_c   = (h_cnt_q < CNT_W'(H_ACTIVE)) && (v_cnt_q < CNT_W'(V_ACTIVE));
        rd_addr_c  = row_base_q + ADDR_W'(h_cnt_q[CNT_W-1:3]);
        wr_ok_c    = fb.fb_we && (fb.fb_addr < ADDR_W'(FB_DEPTH));

        h_cnt_d    = h_wrap_c ? '0 : h_cnt_q + CNT_W'(1);
        v_cnt_d    = v_cnt_q;
        row_base_d = row_base_q;
        if (h_wrap_c) begin
            if (v_wrap_c) begin
                v_cnt_d    = '0;
                row_base_d = '0;
            end else begin
                v_cnt_d = v_cnt_q + CNT_W'(1);
                // leaving the last pixel row of a cell row moves to the next cell row
                if ((v_cnt_q < CNT_W'(V_ACTIVE)) && (v_cnt_q[2:0] == 3'd7)) begin
                    row_base_d = row_base_q + ADDR_W'(CELLS_X);
                end
            end
        end

        act1_d = active_c;
        hs1_d  = !((h_cnt_q >= CNT_W'(HS_START)) && (h_cnt_q < CNT_W'(HS_STOP)));
        vs1_d  = !((v_cnt_q >= CNT_W'(VS_START)) && (v_cnt_q < CNT_W'(VS_STOP)));
        vb1_d  = (v_cnt_q >= CNT_W'(V_ACTIVE));
        fs1_d  = (h_cnt_q == '0) && (v_cnt_q == '0);

        // RGB332 to 4:4:4 by replicating the top bits into the missing LSBs
        r_d  = act1_q ? {rd_data_q[7:5], rd_data_q[7]} : 4'h0;
        g_d  = act1_q ? {rd_data_q[4:2], rd_data_q[4]} : 4'h0;
        b_d  = act1_q ? {rd_data_q[1:0], rd_data_q[1:0]} : 4'h0;
        hs_d = hs1_q;
        vs_d = vs1_q;
        vb_d = vb1_q;
        fs_d = fs1_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            h_cnt_q    <= '0;
            v_cnt_q    <= '0;
            row_base_q <= '0;
            act1_q     <= 1'b0;
            hs1_q      <= 1'b1;
            vs1_q      <= 1'b1;
            vb1_q      <= 1'b0;
            fs1_q      <= 1'b0;
            r_q        <= '0;
            g_q        <= '0;
            b_q        <= '0;
            hs_q       <= 1'b1;
            vs_q       <= 1'b1;
            vb_q       <= 1'b0;
            fs_q       <= 1'b0;
        end else begin
            h_cnt_q    <= h_cnt_d;
            v_cnt_q    <= v_cnt_d;
            row_base_q <= row_base_d;
            act1_q     <= act1_d;
            hs1_q      <= hs1_d;
            vs1_q      <= vs1_d;
            vb1_q      <= vb1_d;
            fs1_q      <= fs1_d;
            r_q        <= r_d;
            g_q        <= g_d;
            b_q        <= b_d;
            hs_q       <= hs_d;
            vs_q       <= vs_d;
            vb_q       <= vb_d;
            fs_q       <= fs_d;
        end
    end

    // Cell buffer: writes ignore reset; a same-address read sees the old byte.
    always_ff @(posedge clk) begin
        if (wr_ok_c) begin
            mem[fb.fb_addr] <= fb.fb_data;
        end
        if (!rst_n) begin
            rd_data_q <= '0;
        end else if (active_c) begin
            rd_data_q <= mem[rd_addr_c];
        end
    end

    assign vga_r       = r_q;
    assign vga_g       = g_q;
    assign vga_b       = b_q;
    assign vga_hs      = hs_q;
    assign vga_vs      = vs_q;
    assign vblank      = vb_q;
    assign frame_start = fs_q;

endmodule

// File: tb/tb_fb_scanout.sv
// Scoreboard bench: full-size timing plus a shrunken-timing instance that
// completes many frames, both fed by one write bus and one reference buffer.
module tb_fb_scanout;

    localparam int unsigned DEPTH = 4800;
    localparam int unsigned HA [2] = '{640, 64};
    localparam int unsigned HF [2] = '{16, 4};
    localparam int unsigned HS [2] = '{96, 8};
    localparam int unsigned HB [2] = '{48, 4};
    localparam int unsigned VA [2] = '{480, 32};
    localparam int unsigned VF [2] = '{10, 2};
    localparam int unsigned VS [2] = '{2, 2};
    localparam int unsigned VB [2] = '{33, 3};
    localparam int unsigned CX [2] = '{80, 8};

    typedef struct packed {
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
        logic       hs;
        logic       vs;
        logic       vb;
        logic       fs;
    } out_t;

    typedef struct {
        out_t        o;
        logic        rst;
        int unsigned p;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #20 clk = ~clk;

    fb_scanout_if bus ();

    logic [1:0][3:0] vr, vg, vb;
    logic [1:0]      vhs, vvs, vblk, vfs;

    fb_scanout u_big (
        .clk(clk), .rst_n(rst_n), .fb(bus),
        .vga_r(vr[0]), .vga_g(vg[0]), .vga_b(vb[0]),
        .vga_hs(vhs[0]), .vga_vs(vvs[0]), .vblank(vblk[0]), .frame_start(vfs[0])
    );

    fb_scanout #(
        .H_ACTIVE(64), .H_FP(4), .H_SYNC(8), .H_BP(4),
        .V_ACTIVE(32), .V_FP(2), .V_SYNC(2), .V_BP(3),
        .CELLS_X(8), .FB_DEPTH(4800)
    ) u_small (
        .clk(clk), .rst_n(rst_n), .fb(bus),
        .vga_r(vr[1]), .vga_g(vg[1]), .vga_b(vb[1]),
        .vga_hs(vhs[1]), .vga_vs(vvs[1]), .vblank(vblk[1]), .frame_start(vfs[1])
    );

    logic [7:0]  ref_mem [DEPTH];
    exp_t        exp_q [2][$];
    int unsigned pos [2];
    int          checks = 0;
    int          errors = 0;

    function automatic int unsigned htot(input int i);
        return HA[i] + HF[i] + HS[i] + HB[i];
    endfunction

    function automatic int unsigned vtot(input int i);
        return VA[i] + VF[i] + VS[i] + VB[i];
    endfunction

    // Expected pins for frame position p of instance i, from the screen geometry
    function automatic out_t model(input int i, input int unsigned p);
        out_t        o;
        int unsigned x, y, rr, gg, bb;
        logic [7:0]  c;
        x    = p % htot(i);
        y    = p / htot(i);
        o.hs = !((x >= HA[i] + HF[i]) && (x < HA[i] + HF[i] + HS[i]));
        o.vs = !((y >= VA[i] + VF[i]) && (y < VA[i] + VF[i] + VS[i]));
        o.vb = (y >= VA[i]);
        o.fs = (p == 0);
        o.r  = 4'h0;
        o.g  = 4'h0;
        o.b  = 4'h0;
        if ((x < HA[i]) && (y < VA[i])) begin
            c   = ref_mem[(y / 8) * CX[i] + x / 8];
            rr  = int'(c[7:5]);
            gg  = int'(c[4:2]);
            bb  = int'(c[1:0]);
            o.r = 4'((rr * 15 + 3) / 7);
            o.g = 4'((gg * 15 + 3) / 7);
            o.b = 4'(bb * 5);
        end
        return o;
    endfunction

    function automatic out_t rst_out();
        out_t o;
        o = '0;
        o.hs = 1'b1;
        o.vs = 1'b1;
        return o;
    endfunction

    // Expectation producer: reads the reference buffer before this edge's write lands
    always @(posedge clk) begin
        exp_t e;
        for (int i = 0; i < 2; i++) begin
            if (!rst_n) begin
                exp_q[i].delete();
                e.o   = rst_out();
                e.rst = 1'b1;
                e.p   = 0;
                exp_q[i].push_back(e);
                exp_q[i].push_back(e);
                pos[i] = 0;
            end else begin
                e.o   = model(i, pos[i]);
                e.rst = 1'b0;
                e.p   = pos[i];
                exp_q[i].push_back(e);
                pos[i] = (pos[i] + 1) % (htot(i) * vtot(i));
            end
        end
        if (bus.fb_we && (int'(bus.fb_addr) < DEPTH)) begin
            ref_mem[bus.fb_addr] = bus.fb_data;
        end
    end

    // Monitor: outputs for an expectation are valid after the following edge
    always @(negedge clk) begin
        exp_t e;
        out_t a;
        for (int i = 0; i < 2; i++) begin
            if (exp_q[i].size() >= 2) begin
                e = exp_q[i].pop_front();
                a = {vr[i], vg[i], vb[i], vhs[i], vvs[i], vblk[i], vfs[i]};
                checks++;
                if (a !== e.o) begin
                    errors++;
                    $display("FAIL %s %s x=%0d y=%0d got rgb=%h%h%h hs=%b vs=%b vb=%b fs=%b exp rgb=%h%h%h hs=%b vs=%b vb=%b fs=%b",
                             (i == 0) ? "big" : "small", e.rst ? "reset" : "pixel",
                             e.p % htot(i), e.p / htot(i),
                             a.r, a.g, a.b, a.hs, a.vs, a.vb, a.fs,
                             e.o.r, e.o.g, e.o.b, e.o.hs, e.o.vs, e.o.vb, e.o.fs);
                end
            end
        end
    end

    // Direct check of the pins against the reset values
    task automatic check_reset_pins();
        out_t a;
        for (int i = 0; i < 2; i++) begin
            a = {vr[i], vg[i], vb[i], vhs[i], vvs[i], vblk[i], vfs[i]};
            checks++;
            if (a !== rst_out()) begin
                errors++;
                $display("FAIL %s reset-state pins got %h exp %h",
                         (i == 0) ? "big" : "small", a, rst_out());
            end
        end
    endtask

    task automatic put(input logic we, input int unsigned a, input logic [7:0] d);
        @(negedge clk);
        bus.fb_we   = we;
        bus.fb_addr = 13'(a);
        bus.fb_data = d;
    endtask

    // One cycle of randomized traffic, including deliberate same-cycle collisions
    task automatic random_cycle();
        int unsigned sel, x, y;
        @(negedge clk);
        sel         = $urandom_range(0, 99);
        bus.fb_we   = 1'b0;
        bus.fb_data = 8'($urandom());
        x = pos[0] % htot(0);
        y = pos[0] / htot(0);
        if (sel < 10 && x < HA[0] && y < VA[0]) begin
            bus.fb_we   = 1'b1;
            bus.fb_addr = 13'((y / 8) * CX[0] + x / 8);
        end else if (sel < 40) begin
            bus.fb_we   = 1'b1;
            bus.fb_addr = 13'($urandom_range(0, 1279));
        end else if (sel < 48) begin
            bus.fb_we   = 1'b1;
            bus.fb_addr = 13'($urandom_range(0, 8191));
        end else if (sel < 60) begin
            bus.fb_we   = 1'b1;
            bus.fb_addr = 13'($urandom_range(0, 31));
        end
    endtask

    initial begin
        logic [1:0] fs_seen;
        bus.fb_we   = 1'b0;
        bus.fb_addr = '0;
        bus.fb_data = '0;
        rst_n       = 1'b0;

        // buffer is loaded while the scan is held in reset
        for (int i = 0; i < 5; i++) put(1'b0, 0, 8'h00);
        check_reset_pins();
        for (int a = 0; a < int'(DEPTH); a++) put(1'b1, a, 8'hFF);
        put(1'b1, 0, 8'hE0);
        put(1'b1, 4799, 8'h03);
        put(1'b1, 4800, 8'hFF);
        put(1'b1, 4800 + 704, 8'h1C);
        put(1'b1, 8191, 8'h55);
        put(1'b0, 0, 8'h00);
        check_reset_pins();
        rst_n = 1'b1;

        // bounded wait for the first frame_start after release
        fs_seen = 2'b00;
        for (int i = 0; i < 8; i++) begin
            put(1'b0, 0, 8'h00);
            fs_seen = fs_seen | vfs;
        end
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (!fs_seen[i]) begin
                errors++;
                $display("FAIL %s frame_start not seen within 8 cycles of reset release",
                         (i == 0) ? "big" : "small");
            end
        end

        for (int i = 0; i < 1192; i++) put(1'b0, 0, 8'h00);
        for (int i = 0; i < 38000; i++) random_cycle();

        // one-cycle reset in the middle of a frame
        @(negedge clk);
        bus.fb_we = 1'b0;
        rst_n     = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 12000; i++) random_cycle();
        for (int i = 0; i < 4; i++) put(1'b0, 0, 8'h00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
